// File: rtl/packer_fsm.sv
// packer_fsm: gathers 32-byte beats into 160-byte words, keeping the
// val/sop/eop/vbc framing. Up to OUT_BEATS beats of one packet go into one
// wide word; the word is emitted on its OUT_BEATS-th beat or on eop.
//
// Ports:
//   clk, reset_L          clock (posedge), asynchronous active-low reset
//   val/sop/eop/vbc/data  input beat; accepted when val && ready
//   ready                 upstream may present a beat
//   o_val/o_sop/o_eop     output word framing, held until o_val && o_ready
//   o_vbc/o_data          valid byte count (1..160) and packed word
//   o_ready               downstream consumes the word
//   idle                  no packet open and output register empty
//   err                   sticky protocol error (0 unless PACKER_PROTO_CHK_EN)
//   dbg_state             current FSM state (IDLE=0, ACCUM=1, HOLD=2)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; a valid holder keeps its payload stable until that edge, and
// ready never depends on val (input side) or on o_val (output side, from the
// consumer's point of view).
//
// Build option: define PACKER_PROTO_CHK_EN to discard and flag malformed
// beats (sop inside a packet, missing sop, vbc out of range, short non-eop).
//
// Byte order: a word of n beats occupies slices n-1..0, first beat in the
// highest used slice, unused upper slices zero.

module packer_fsm #(
    parameter int IN_BYTES  = 32,
    parameter int OUT_BEATS = 5
) (
    input  logic                            clk,
    input  logic                            reset_L,
    input  logic                            val,
    input  logic                            sop,
    input  logic                            eop,
    input  logic [7:0]                      vbc,
    input  logic [IN_BYTES*8-1:0]           data,
    output logic                            ready,
    output logic                            o_val,
    output logic                            o_sop,
    output logic                            o_eop,
    output logic [7:0]                      o_vbc,
    output logic [IN_BYTES*OUT_BEATS*8-1:0] o_data,
    input  logic                            o_ready,
    output logic                            idle,
    output logic                            err,
    output logic [1:0]                      dbg_state
);

    localparam int IN_W  = IN_BYTES * 8;
    localparam int OUT_W = IN_W * OUT_BEATS;
    localparam int CNT_W = $clog2(OUT_BEATS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   acc_data_q, acc_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         acc_vbc_q, acc_vbc_d;
    logic               acc_sop_q, acc_sop_d;
    logic               acc_eop_q, acc_eop_d;

    logic               o_val_q, o_val_d;
    logic               o_sop_q, o_sop_d;
    logic               o_eop_q, o_eop_d;
    logic [7:0]         o_vbc_q, o_vbc_d;
    logic [OUT_W-1:0]   o_data_q, o_data_d;

    logic               can_load;
    logic               take;
    logic               bad;
    logic               accept;
    logic               hold_load;

    // Accumulator as seen by an incoming beat: empty when the held word
    // leaves the accumulator at this same edge.
    logic [OUT_W-1:0]   base_data;
    logic [CNT_W-1:0]   base_cnt;
    logic [7:0]         base_vbc;
    logic               base_sop;

    logic [OUT_W-1:0]   new_data;
    logic [CNT_W-1:0]   new_cnt;
    logic [7:0]         new_vbc;
    logic               new_sop;
    logic               close;

    assign can_load  = !o_val_q || o_ready;
    assign ready     = (state_q != ST_HOLD) || can_load;
    assign take      = val && ready;
    assign hold_load = (state_q == ST_HOLD) && can_load;

`ifdef PACKER_PROTO_CHK_EN
    logic pkt_open;
    logic err_q, err_d;

    // In HOLD the packet is still open unless the held word carried eop.
    assign pkt_open = (state_q == ST_ACCUM) || ((state_q == ST_HOLD) && !acc_eop_q);
    assign bad = (sop && pkt_open) || (!sop && !pkt_open) ||
                 (vbc == 8'd0) || (vbc > 8'(IN_BYTES)) ||
                 (!eop && (vbc != 8'(IN_BYTES)));
    assign err_d = err_q || (take && bad);
    assign err   = err_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign bad = 1'b0;
    assign err = 1'b0;
`endif

    assign accept = take && !bad;

    assign base_data = hold_load ? '0 : acc_data_q;
    assign base_cnt  = hold_load ? '0 : cnt_q;
    assign base_vbc  = hold_load ? '0 : acc_vbc_q;
    assign base_sop  = hold_load ? 1'b0 : acc_sop_q;

    // Earlier beats move up one slice; the new beat lands in slice 0.
    assign new_data = (base_data << IN_W) | {{(OUT_W-IN_W){1'b0}}, data};
    assign new_cnt  = base_cnt + 1'b1;
    assign new_vbc  = base_vbc + vbc;
    assign new_sop  = (base_cnt == '0) ? sop : base_sop;
    assign close    = (new_cnt == CNT_W'(OUT_BEATS)) || eop;

    always_comb begin
        state_d    = state_q;
        acc_data_d = acc_data_q;
        cnt_d      = cnt_q;
        acc_vbc_d  = acc_vbc_q;
        acc_sop_d  = acc_sop_q;
        acc_eop_d  = acc_eop_q;
        o_val_d    = o_val_q;
        o_sop_d    = o_sop_q;
        o_eop_d    = o_eop_q;
        o_vbc_d    = o_vbc_q;
        o_data_d   = o_data_q;

        if (o_val_q && o_ready) begin
            o_val_d = 1'b0;
        end

        // The held word moves to the output; a load always wins over consume.
        if (hold_load) begin
            o_val_d    = 1'b1;
            o_data_d   = acc_data_q;
            o_vbc_d    = acc_vbc_q;
            o_sop_d    = acc_sop_q;
            o_eop_d    = acc_eop_q;
            acc_data_d = '0;
            cnt_d      = '0;
            acc_vbc_d  = '0;
            acc_sop_d  = 1'b0;
            acc_eop_d  = 1'b0;
            state_d    = acc_eop_q ? ST_IDLE : ST_ACCUM;
        end

        if (accept) begin
            if (close && !hold_load && can_load) begin
                o_val_d    = 1'b1;
                o_data_d   = new_data;
                o_vbc_d    = new_vbc;
                o_sop_d    = new_sop;
                o_eop_d    = eop;
                acc_data_d = '0;
                cnt_d      = '0;
                acc_vbc_d  = '0;
                acc_sop_d  = 1'b0;
                acc_eop_d  = 1'b0;
                state_d    = eop ? ST_IDLE : ST_ACCUM;
            end else begin
                // Either still partial, or complete but the output register
                // is taken (possibly by the word that just left HOLD).
                acc_data_d = new_data;
                cnt_d      = new_cnt;
                acc_vbc_d  = new_vbc;
                acc_sop_d  = new_sop;
                acc_eop_d  = eop;
                state_d    = close ? ST_HOLD : ST_ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_IDLE;
            acc_data_q <= '0;
            cnt_q      <= '0;
            acc_vbc_q  <= '0;
            acc_sop_q  <= 1'b0;
            acc_eop_q  <= 1'b0;
            o_val_q    <= 1'b0;
            o_sop_q    <= 1'b0;
            o_eop_q    <= 1'b0;
            o_vbc_q    <= '0;
            o_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            acc_data_q <= acc_data_d;
            cnt_q      <= cnt_d;
            acc_vbc_q  <= acc_vbc_d;
            acc_sop_q  <= acc_sop_d;
            acc_eop_q  <= acc_eop_d;
            o_val_q    <= o_val_d;
            o_sop_q    <= o_sop_d;
            o_eop_q    <= o_eop_d;
            o_vbc_q    <= o_vbc_d;
            o_data_q   <= o_data_d;
        end
    end

    assign o_val     = o_val_q;
    assign o_sop     = o_sop_q;
    assign o_eop     = o_eop_q;
    assign o_vbc     = o_vbc_q;
    assign o_data    = o_data_q;
    assign idle      = (state_q == ST_IDLE) && !o_val_q;
    assign dbg_state = state_q;

endmodule

// File: doc/packer_fsm.md
Name: packer_fsm

Overview:
- Re-packs a stream of 32-byte beats into 160-byte words carrying the same val/sop/eop/vbc framing.
- It is the inverse of the 160-to-32 unpacker and sits upstream of it on the wide bus, or after a narrow-bus stage.
- Up to five beats of one packet are gathered into one wide word. A word is emitted on its fifth beat or on eop, whichever comes first.
- Upstream backpressure is provided via `ready`; downstream backpressure is accepted via `o_ready`.

Parameters:
- IN_BYTES, 32, bytes per input beat (slice width is IN_BYTES*8 bits).
- OUT_BEATS, 5, beats per output word (output is IN_BYTES*OUT_BEATS bytes).

Ports:
- clk  in  1  clock, all logic on posedge.
- reset_L  in  1  asynchronous, active-low reset.
- val  in  1  input beat valid.
- sop  in  1  first beat of packet.
- eop  in  1  last beat of packet.
- vbc  in  8  valid bytes in beat, 1..32.
- data  in  256  beat payload.
- ready  out  1  beat accepted when val && ready.
- o_val  out  1  output word valid.
- o_sop  out  1  word contains packet's first beat.
- o_eop  out  1  word contains packet's last beat.
- o_vbc  out  8  valid bytes in word, 1..160.
- o_data  out  1280  packed word.
- o_ready  in  1  downstream consumes word when o_val && o_ready.
- idle  out  1  no packet open, accumulator empty, output empty.
- err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset is asynchronous on reset_L low. While low and on release:
  - all outputs 0, except ready = 1 and idle = 1;
  - accumulator cleared; state = IDLE.
  - A reset mid-packet discards all partial data and any unread output word.
- Accept: a beat is taken when val && ready.
- Accumulator holds acc_data (1280 b), cnt (0..5), acc_vbc (0..160), acc_sop and acc_eop.
- On each accept:
  - acc_data <= {acc_data[1023:0], data}, so the first beat ends in slice cnt-1 and the last beat in slice 0.
  - cnt += 1; acc_vbc += vbc.
  - acc_sop |= sop when cnt == 0; acc_eop = eop.
- Byte order matches the unpacker:
  - a word of n beats occupies slices n-1..0, with the first beat in the highest used slice;
  - unused upper slices are 0;
  - a short last beat is passed through unaligned.
- Close condition: the accepted beat makes cnt == OUT_BEATS, or it has eop.
- can_load = !o_val || o_ready.
- State machine:
  - IDLE: no packet open. An accept with sop goes to ACCUM, or loads directly if it closes the word (single-beat packet).
  - ACCUM: packet open, accumulator partial. An accept that closes the word:
    - if can_load, the output register is loaded at the same edge and the state goes to IDLE (eop) or stays in ACCUM with the accumulator cleared (5 beats, no eop);
    - otherwise the state goes to HOLD.
  - HOLD: the word is complete but the output is occupied. ready = can_load. When can_load, the word loads and the accumulator clears. A beat accepted in that same cycle starts the new accumulator. The next state is IDLE or ACCUM according to acc_eop and the new beat.
- ready = (state != HOLD) || can_load.
- Latency: the closing beat accepted at edge t gives o_val = 1 after edge t when can_load, i.e. one cycle of latency.
- Output register:
  - loaded with o_data = acc_data (including the closing beat), o_vbc = acc_vbc, o_sop = acc_sop, o_eop = acc_eop.
  - o_val is held, with all o_* stable, until o_val && o_ready.
  - It clears on consume unless reloaded at the same edge (back-to-back words at full rate).
- Simultaneous events: consume and load in the same cycle are allowed; the load wins.
- vbc arithmetic: acc_vbc is 8 bits and at most 160; no wrap is possible when beats are legal.
- idle = (state == IDLE) && !o_val.

Optional Feature:
- Macro: PACKER_PROTO_CHK_EN.
- Defined: the following beats set err (sticky until reset) and are consumed and discarded. They do not change the accumulator or state.
  - sop while a packet is open;
  - a beat without sop while IDLE;
  - vbc == 0 or vbc > 32;
  - a non-eop beat with vbc != 32.
- Undefined: err is tied 0 and all beats are packed as received.

Test Plan:
- Single beat B0 (sop, eop, vbc = 20), o_ready = 1 -> next cycle: o_val = 1, o_sop = 1, o_eop = 1, o_vbc = 20, o_data[255:0] = B0, upper slices 0; idle = 1 the cycle after.
- Five beats B0..B4 (vbc = 32; sop on B0, eop on B4) -> one word: o_vbc = 160, o_sop = o_eop = 1, slice 4 = B0, slice 0 = B4.
- Seven beats, last vbc = 10 -> word 1: vbc = 160, sop = 1, eop = 0. Word 2: vbc = 42, sop = 0, eop = 1, slice 1 = B5, slice 0 = B6, slices 4..2 = 0.
- o_ready = 0 while word 1 is valid and word 2 closes -> state HOLD, ready = 0, o_* stable. Raise o_ready -> word 1 then word 2 are delivered in order, and ready returns to 1 in the consume cycle.
- Assert reset_L = 0 after 3 beats of a packet -> all outputs 0 asynchronously. After release, a new 2-beat packet produces vbc = 64, sop = 1, with no stale data.
- With PACKER_PROTO_CHK_EN: a non-eop beat with vbc = 16 -> err = 1 and stays 1, the beat is discarded, and o_vbc of the word excludes it.
